// File: rtl/canvas_pkg.sv
// Shared types and canvas geometry for the framebuffer arbiter slice.
package canvas_pkg;
    localparam int CANVAS_W     = 160;
    localparam int CANVAS_H     = 120;
    localparam int CANVAS_CELLS = CANVAS_W * CANVAS_H;
    localparam int ADDR_W       = 15;
    localparam int COLOR_W      = 4;

    typedef logic [ADDR_W-1:0]  canvas_addr_t;
    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} arb_state_t;

    typedef struct packed {
        canvas_addr_t addr;
        color_t       color;
    } draw_req_t;

    localparam canvas_addr_t LAST_CELL = canvas_addr_t'(CANVAS_CELLS - 1);

    function automatic logic in_canvas(input canvas_addr_t a);
        return a < canvas_addr_t'(CANVAS_CELLS);
    endfunction
endpackage

// File: rtl/canvas_mem_arbiter_if.sv
// Requester and BRAM-side signals of the canvas arbiter; slave = arbiter view.
interface canvas_mem_arbiter_if;
    import canvas_pkg::*;

    logic         disp_req;
    canvas_addr_t disp_addr;
    color_t       disp_rdata;
    logic         disp_rvalid;
    logic         draw_valid;
    logic         draw_ready;
    canvas_addr_t draw_addr;
    color_t       draw_color;
    logic         clear_req;
    logic         clear_busy;
    logic         mem_en;
    logic         mem_we;
    canvas_addr_t mem_addr;
    color_t       mem_wdata;
    color_t       mem_rdata;

    modport slave (
        input  disp_req, disp_addr, draw_valid, draw_addr, draw_color, clear_req, mem_rdata,
        output disp_rdata, disp_rvalid, draw_ready, clear_busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, draw_valid, draw_addr, draw_color, clear_req, mem_rdata,
        input  disp_rdata, disp_rvalid, draw_ready, clear_busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/canvas_wr_fifo.sv
// Synchronous FIFO of paint-write requests with flush; DEPTH must be a power of 2, >= 2.
module canvas_wr_fifo
    import canvas_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  draw_req_t                din_i,
    output draw_req_t                dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("canvas_wr_fifo: DEPTH must be a power of 2 and at least 2");
    end

    draw_req_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
endmodule

// File: rtl/canvas_mem_arbiter.sv
// Framebuffer port arbiter: display reads > clear sweep > buffered paint writes.
// Optional CANVAS_ARB_STATS_EN adds saturating stall/drop counters.
module canvas_mem_arbiter
    import canvas_pkg::*;
#(
    parameter int     FIFO_DEPTH  = 8,
    parameter color_t CLEAR_COLOR = 4'h0
) (
    input logic                 pixel_clk_25,
    input logic                 reset,
    canvas_mem_arbiter_if.slave bus
`ifdef CANVAS_ARB_STATS_EN
    ,
    output logic [15:0]         stall_count,
    output logic [15:0]         drop_count
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_t   state_q, state_d;
    canvas_addr_t sweep_q, sweep_d;
    logic         rvalid_q;
    logic         disp_gnt, fifo_push, fifo_pop, fifo_flush;
    logic         fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    draw_req_t    fifo_head, draw_in;
    logic         mem_en, mem_we;
    canvas_addr_t mem_addr;
    color_t       mem_wdata;

    assign draw_in        = '{addr: bus.draw_addr, color: bus.draw_color};
    assign bus.draw_ready = (state_q == IDLE) && !fifo_full && !reset;
    assign fifo_push      = bus.draw_valid && bus.draw_ready;

    canvas_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk_i   (pixel_clk_25),
        .rst_i   (reset),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (draw_in),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Memory port is driven straight from the grant; reset gates every access.
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        disp_gnt   = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (!reset) begin
            if (bus.disp_req) begin
                disp_gnt = 1'b1;
                mem_en   = 1'b1;
                mem_addr = bus.disp_addr;
            end else if (state_q == CLEAR) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sweep_q;
                mem_wdata = CLEAR_COLOR;
                sweep_d   = sweep_q + canvas_addr_t'(1);
                if (sweep_q == LAST_CELL) state_d = IDLE;
            end else if (!fifo_empty) begin
                fifo_pop = 1'b1;
                if (in_canvas(fifo_head.addr)) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = fifo_head.addr;
                    mem_wdata = fifo_head.color;
                end
            end
            if (state_q == IDLE && bus.clear_req) begin
                state_d    = CLEAR;
                sweep_d    = '0;
                fifo_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk_25) begin
        if (reset) begin
            state_q  <= IDLE;
            sweep_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            rvalid_q <= disp_gnt;
        end
    end

    always_ff @(posedge pixel_clk_25) begin
        if (!reset) assert (fifo_count <= CNT_W'(FIFO_DEPTH));
    end

    assign bus.mem_en      = mem_en;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.disp_rvalid = rvalid_q;
    assign bus.disp_rdata  = bus.mem_rdata;
    assign bus.clear_busy  = (state_q == CLEAR);

`ifdef CANVAS_ARB_STATS_EN
    logic [15:0] stall_q, drop_q;
    logic        drop_wr;

    assign drop_wr = fifo_pop && !in_canvas(fifo_head.addr);

    always_ff @(posedge pixel_clk_25) begin
        if (reset || fifo_flush) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            if (bus.draw_valid && !bus.draw_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (drop_wr && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
    assign drop_count  = drop_q;
`endif
endmodule

// File: tb/tb_canvas_mem_arbiter.sv
// Directed bench for canvas_mem_arbiter with a behavioural 1-cycle-latency BRAM.
module tb_canvas_mem_arbiter;
    import canvas_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    canvas_mem_arbiter_if bus();

`ifdef CANVAS_ARB_STATS_EN
    logic [15:0] stall_count, drop_count;
`endif

    canvas_mem_arbiter #(.FIFO_DEPTH(8), .CLEAR_COLOR(4'h0)) dut (
        .pixel_clk_25 (clk),
        .reset        (rst),
        .bus          (bus)
`ifdef CANVAS_ARB_STATS_EN
        ,
        .stall_count  (stall_count),
        .drop_count   (drop_count)
`endif
    );

    // BRAM model: preset to 0xF with 0xA at cell 100 on the first clock.
    logic [3:0] bram [0:32767];
    logic [3:0] rdq = 4'h0;
    bit         bram_init = 1'b0;
    always @(posedge clk) begin
        if (!bram_init) begin
            for (int i = 0; i < 32768; i++) bram[i] <= 4'hF;
            bram[100] <= 4'hA;
            bram_init <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
            else            rdq <= bram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rdq;

    typedef struct packed {
        logic dr; logic [14:0] da; logic dv; logic [14:0] wa; logic [3:0] wc;
        logic en; logic we; logic [14:0] ma; logic [3:0] md; logic rdy; logic rv; logic [3:0] rd;
    } vec_t;

    function automatic vec_t mkv(int dr, int da, int dv, int wa, int wc,
                                 int en, int we, int ma, int md, int rdy, int rv, int rd);
        vec_t v;
        v.dr = 1'(dr); v.da = 15'(da); v.dv = 1'(dv); v.wa = 15'(wa); v.wc = 4'(wc);
        v.en = 1'(en); v.we = 1'(we); v.ma = 15'(ma); v.md = 4'(md);
        v.rdy = 1'(rdy); v.rv = 1'(rv); v.rd = 4'(rd);
        return v;
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        bus.disp_req = 1'b0; bus.disp_addr = '0; bus.draw_valid = 1'b0;
        bus.draw_addr = '0; bus.draw_color = '0; bus.clear_req = 1'b0;
    endtask

    task automatic check_read(input string name, input int a, input int exp);
        bus.disp_req = 1'b1; bus.disp_addr = 15'(a);
        tick();
        bus.disp_req = 1'b0;
        @(negedge clk);
        chk(name, {27'd0, bus.disp_rvalid, bus.disp_rdata}, {27'd0, 1'b1, 4'(exp)});
        tick();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vt [16];

    initial begin
        int acc, bad, got, n, idx;
        logic rdy, ok, seen;

        vt[0]  = mkv(0, 0,   1, 5,     3, 0, 0, 0,   0, 1, 0, 0);
        vt[1]  = mkv(0, 0,   1, 6,     7, 1, 1, 5,   3, 1, 0, 0);
        vt[2]  = mkv(0, 0,   1, 7,     9, 1, 1, 6,   7, 1, 0, 0);
        vt[3]  = mkv(0, 0,   0, 0,     0, 1, 1, 7,   9, 1, 0, 0);
        vt[4]  = mkv(0, 0,   0, 0,     0, 0, 0, 0,   0, 1, 0, 0);
        vt[5]  = mkv(1, 100, 1, 8,     2, 1, 0, 100, 0, 1, 0, 0);
        vt[6]  = mkv(0, 0,   0, 0,     0, 1, 1, 8,   2, 1, 1, 10);
        vt[7]  = mkv(1, 8,   0, 0,     0, 1, 0, 8,   0, 1, 0, 0);
        vt[8]  = mkv(0, 0,   0, 0,     0, 0, 0, 0,   0, 1, 1, 2);
        vt[9]  = mkv(0, 0,   1, 19200, 5, 0, 0, 0,   0, 1, 0, 0);
        vt[10] = mkv(0, 0,   0, 0,     0, 0, 0, 0,   0, 1, 0, 0);
        vt[11] = mkv(0, 0,   1, 9,     1, 0, 0, 0,   0, 1, 0, 0);
        vt[12] = mkv(0, 0,   1, 9,     4, 1, 1, 9,   1, 1, 0, 0);
        vt[13] = mkv(0, 0,   0, 0,     0, 1, 1, 9,   4, 1, 0, 0);
        vt[14] = mkv(1, 9,   0, 0,     0, 1, 0, 9,   0, 1, 0, 0);
        vt[15] = mkv(0, 0,   0, 0,     0, 0, 0, 0,   0, 1, 1, 4);

        // Reset cycle with requests present: everything must be quiet.
        idle_in();
        bus.disp_req = 1'b1; bus.disp_addr = 15'd3; bus.draw_valid = 1'b1;
        @(negedge clk);
        chk("reset_outputs",
            {8'd0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.draw_ready, bus.disp_rvalid, bus.clear_busy},
            32'd0);
        tick();
        rst = 1'b0;
        idle_in();

        for (int i = 0; i < 16; i++) begin
            bus.disp_req = vt[i].dr; bus.disp_addr = vt[i].da;
            bus.draw_valid = vt[i].dv; bus.draw_addr = vt[i].wa; bus.draw_color = vt[i].wc;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {8'd0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.draw_ready, bus.disp_rvalid},
                {8'd0, vt[i].en, vt[i].we, vt[i].ma, vt[i].md, vt[i].rdy, vt[i].rv});
            if (vt[i].rv) chk($sformatf("vec%0d_rdata", i), {28'd0, bus.disp_rdata}, {28'd0, vt[i].rd});
            tick();
        end
        idle_in();
`ifdef CANVAS_ARB_STATS_EN
        chk("drop_count_one", {16'd0, drop_count}, 32'd1);
`endif

        // Fill under continuous display traffic: 8 accepted, no writes.
        acc = 0; bad = 0; rdy = 1'b1;
        bus.disp_req = 1'b1; bus.disp_addr = '0;
        for (int c = 0; c < 10; c++) begin
            bus.draw_valid = 1'b1; bus.draw_addr = 15'(20 + acc); bus.draw_color = 4'(acc);
            @(negedge clk);
            if (bus.mem_we) bad++;
            rdy = bus.draw_ready;
            if (rdy) acc++;
            tick();
        end
        chk("fill_accepted", acc, 8);
        chk("fill_no_write", bad, 0);
        chk("fill_ready_low", {31'd0, rdy}, 32'd0);

        // Release display: 9 writes drain in order, ready comes back.
        bus.disp_req = 1'b0; got = 0; ok = 1'b1; seen = 1'b0;
        for (int c = 0; c < 20 && got < 9; c++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                if (bus.mem_addr != 15'(20 + got) || bus.mem_wdata != 4'(got)) ok = 1'b0;
                got++;
            end
            if (bus.draw_ready) seen = 1'b1;
            rdy = bus.draw_valid && bus.draw_ready;
            tick();
            if (rdy) bus.draw_valid = 1'b0;
        end
        chk("drain_count", got, 9);
        chk("drain_order", {31'd0, ok}, 32'd1);
        chk("drain_ready_back", {31'd0, seen}, 32'd1);
        idle_in();
        tick();

        // Queue 3 writes behind display, then start a clear: they must be flushed.
        bus.disp_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.draw_valid = 1'b1; bus.draw_addr = 15'(30 + i); bus.draw_color = 4'(i + 1);
            tick();
        end
        bus.draw_valid = 1'b0; bus.clear_req = 1'b1;
        @(negedge clk);
        chk("clear_entry_busy_low", {31'd0, bus.clear_busy}, 32'd0);
        tick();
        bus.clear_req = 1'b0;

        n = 0; idx = 0; bad = 0; acc = 0; seen = 1'b1;
        for (int c = 0; c < 40000; c++) begin
            bus.disp_req = c[0]; bus.disp_addr = 15'd1;
            bus.draw_valid = 1'b1; bus.draw_addr = 15'd40; bus.draw_color = 4'd6;
            @(negedge clk);
            if (!bus.clear_busy) begin
                seen = 1'b0;
                break;
            end
            n++;
            if (bus.draw_ready) acc++;
            if (bus.mem_we) begin
                if (bus.mem_addr != 15'(idx) || bus.mem_wdata != 4'h0) bad++;
                idx++;
            end
            tick();
        end
        chk("sweep_finished", {31'd0, seen}, 32'd0);
        chk("sweep_write_count", idx, 19200);
        chk("sweep_write_seq", bad, 0);
        chk("sweep_ready_low", acc, 0);
        chk("sweep_cycles_min", {31'd0, n >= 19200}, 32'd1);
        tick();
        idle_in();
        repeat (3) tick();
`ifdef CANVAS_ARB_STATS_EN
        chk("stall_count_sweep", {16'd0, stall_count}, n);
        chk("drop_count_cleared", {16'd0, drop_count}, 32'd0);
`endif
        check_read("cell_0", 0, 0);
        check_read("cell_9600", 9600, 0);
        check_read("cell_19199", 19199, 0);
        check_read("flushed_30", 30, 0);
        check_read("flushed_32", 32, 0);
        check_read("post_sweep_40", 40, 6);

        // Abort a sweep with reset when the counter reaches 5000.
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (5000) tick();
        @(negedge clk);
        chk("sweep_at_5000", {16'd0, bus.clear_busy, bus.mem_we, bus.mem_addr}, {16'd0, 1'b1, 1'b1, 15'd5000});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_abort", {29'd0, bus.clear_busy, bus.mem_we, bus.draw_ready}, 32'd1);
        tick();

        // Reset discards queued writes.
        bus.disp_req = 1'b1; bus.draw_valid = 1'b1; bus.draw_addr = 15'd50; bus.draw_color = 4'd7;
        tick();
        bus.draw_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.disp_req = 1'b0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.mem_en) bad++;
            tick();
        end
        chk("reset_discards_fifo", bad, 0);
        check_read("cell_50", 50, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
